cell_window_sequencer: RTL and testbench
========================================

Name: cell_window_sequencer

Overview:
Front-end controller for the 3x3 cell processor. It accepts a raster-order pixel stream for one frame and buffers the two previous image rows. For every interior pixel it assembles a full 3x3 cell and issues it to the cell processor over a valid/ready handshake. The cell is issued together with the opcode and user input latched at frame start.

Parameters:
IMG_W, 640, pixels per row (>=3)
IMG_H, 480, rows per frame (>=3)
PIX_W, 24, pixel width (channelWidth*channelNum)
OP_W, 4, opcode width
(cell size fixed at 3x3; cell width CELL_W = 9*PIX_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin frame; sampled only in IDLE
opcode_in  in  OP_W  operation for this frame, latched on accepted start
user_in  in  PIX_W  immediate operand, latched on accepted start
pix_valid  in  1  input pixel valid
pix_data  in  PIX_W  input pixel, raster order (row 0 col 0 first)
pix_ready  out  1  sequencer accepts pixel this cycle
cell_valid  out  1  cell output valid
cell_ready  in  1  cell processor accepts cell
cell_data  out  CELL_W  3x3 cell, pixelMatrix[k] = cell_data[k*PIX_W +: PIX_W]
cell_x  out  clog2(IMG_W)  centre column of cell_data
cell_y  out  clog2(IMG_H)  centre row of cell_data
opcode  out  OP_W  latched opcode
user_input  out  PIX_W  latched user input
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after final cell handshake

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: pix_ready=0, cell_valid=0, busy=0, frame_done=0. cell_data, cell_x, cell_y, opcode and user_input are all 0. State=IDLE, row/col counters=0. Line buffer contents are don't-care.
- States:
  - IDLE -> LOAD on start (also latches opcode and user input).
  - LOAD (rows 0..1) -> STREAM when pixel (1, IMG_W-1) is accepted.
  - STREAM (rows 2..IMG_H-1) -> FLUSH when pixel (IMG_H-1, IMG_W-1) is accepted.
  - FLUSH -> DONE on handshake of the final cell.
  - DONE -> IDLE after 1 cycle; frame_done=1 only in DONE.
- Pixel acceptance: accepted when pix_valid && pix_ready.
  - pix_ready = (LOAD) || (STREAM && (!cell_valid || cell_ready)).
  - pix_ready = 0 in IDLE, FLUSH and DONE.
- Counters: col increments per accepted pixel and wraps IMG_W-1 -> 0. On wrap, row increments.
- Line buffers: two rows of IMG_W pixels, lb1 = row y-1 and lb0 = row y-2. On acceptance of (y,x): lb0[x] <= lb1[x] and lb1[x] <= pix_data.
- Window: a 3x3 shift register. Each accepted pixel shifts in the column {lb0[x], lb1[x], pix_data}. Row-wrap does not clear the window.
- Cell index mapping: k = 3*dr + dc, where dr=0 is row y-2 and dc=0 is column x-2. Centre pixelMatrix[4] is (y-1, x-1).
- Cell issue: when (y,x) is accepted with y>=2 and x>=2, the next cycle has cell_valid=1 with the updated window, cell_x=x-1 and cell_y=y-1.
  - Latency is 1 cycle from pixel acceptance to cell_valid.
  - Exactly (IMG_W-2)*(IMG_H-2) cells per frame. Border pixels (row/col 0 or max) produce no centred cell.
- Output hold: while cell_valid && !cell_ready, cell_data, cell_x and cell_y are stable and no pixel is accepted. cell_valid clears on handshake unless a new cell loads the same cycle.
- Simultaneous events:
  - Handshake plus new pixel acceptance in the same cycle: the new cell replaces the old one with no bubble.
  - Full throughput is 1 pixel/cycle when cell_ready is held at 1.
- start while busy is ignored. opcode and user_input are stable from accepted start until the next accepted start.
- rst mid-frame:
  - Same-cycle return to reset values. Any pending cell is dropped and frame_done is not pulsed.
  - The next frame requires a new start.
- pix_valid in IDLE, FLUSH or DONE is not accepted; pix_ready stays 0.

Test Plan:
- Small frame, cell_ready=1. Set IMG_W=5, IMG_H=4, start with opcode=4'h1, user_in=24'h0A0B0C, and stream pix(y,x)={8'h00,y,x} at pix_valid=1.
  - Expect 6 cells: (1,1),(2,1),(3,1),(1,2),(2,2),(3,2) as (x,y).
  - First cell: [0]=24'h000000, [4]=24'h000101, [8]=24'h000202.
  - frame_done pulses 2 cycles after the last pixel; opcode=4'h1 throughout.
- Backpressure: same frame, cell_ready=0 for 5 cycles at the first cell.
  - pix_ready=0 and cell_data stays constant during the stall.
  - Release -> the next cell holds centre 24'h000102, i.e. (x=2,y=1); no cell is lost or duplicated.
- Row wrap: check the cell issued at (y=3,x=2) of the 5x4 frame.
  - Expect [0]=24'h000100 and [8]=24'h000302, with no stale pixels from row 2 cols 3-4 in cols 0-2.
- Reset mid-frame: assert rst for 1 cycle after 12 pixels.
  - All outputs return to 0 and frame_done is never asserted.
  - A fresh start plus full frame yields the same 6 cells as scenario 1.
- Start while busy: pulse start with opcode=4'h3 mid-frame -> opcode stays 4'h1 and the cell count is still 6.
- Throughput: full 640x480 frame with continuous valid/ready.
  - Expect 638*478=304964 cells, the last with centre (638,478).
  - Total cycles = 307200+2 from first accept to frame_done.

Source files
------------

// File: rtl/cell_window_sequencer.sv
// cell_window_sequencer
// Front end for the 3x3 cell processor. It accepts one raster-order frame of
// pixels and keeps the two previous rows in line buffers. For every interior
// pixel it issues a 3x3 cell over a valid/ready handshake, together with the
// opcode and user operand latched at frame start.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   start              begin frame (sampled only when idle)
//   opcode_in, user_in frame operation and immediate, latched on start
//   pix_valid/ready    input pixel handshake, pix_data in raster order
//   cell_valid/ready   output cell handshake
//   cell_data          pixelMatrix[k] = cell_data[k*PIX_W +: PIX_W], k = 3*dr + dc
//   cell_x, cell_y     centre coordinates of cell_data
//   opcode, user_input latched frame operands
//   busy               high from accepted start until frame_done
//   frame_done         one-cycle pulse after the final cell handshake
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | filling line buffers, rows 0..1, no cells issued
// STREAM | rows 2..IMG_H-1, a cell per interior pixel
// FLUSH  | last pixel taken, waiting for the final cell handshake
// DONE   | frame_done pulse, back to IDLE
module cell_window_sequencer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 24,
  parameter int OP_W  = 4,
  localparam int CELL_W = 9 * PIX_W,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode_in,
  input  logic [PIX_W-1:0]  user_in,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              cell_valid,
  input  logic              cell_ready,
  output logic [CELL_W-1:0] cell_data,
  output logic [XW-1:0]     cell_x,
  output logic [YW-1:0]     cell_y,
  output logic [OP_W-1:0]   opcode,
  output logic [PIX_W-1:0]  user_input,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, FLUSH, DONE} stateT;

  stateT            state;
  logic [XW-1:0]    col;
  logic [YW-1:0]    row;
  logic [PIX_W-1:0] lb0 [IMG_W];  // row y-2
  logic [PIX_W-1:0] lb1 [IMG_W];  // row y-1
  logic             accept;
  logic             lastCol;
  logic             lastRow;
  logic             handshake;

  // A new pixel is only taken when the output slot is free or being emptied,
  // which keeps cell_data (the window itself) stable during a stall.
  assign pix_ready = (state == LOAD) ||
                     ((state == STREAM) && (!cell_valid || cell_ready));
  assign accept    = pix_valid && pix_ready;
  assign lastCol   = (col == XW'(IMG_W - 1));
  assign lastRow   = (row == YW'(IMG_H - 1));
  assign handshake = cell_valid && cell_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      cell_valid <= 1'b0;
      cell_data  <= '0;
      cell_x     <= '0;
      cell_y     <= '0;
      opcode     <= '0;
      user_input <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (handshake) cell_valid <= 1'b0;

      if (accept) begin
        // Window shift: oldest column (dc=0) drops out, new column enters at dc=2.
        for (int dr = 0; dr < 3; dr++) begin
          cell_data[(3*dr+0)*PIX_W +: PIX_W] <= cell_data[(3*dr+1)*PIX_W +: PIX_W];
          cell_data[(3*dr+1)*PIX_W +: PIX_W] <= cell_data[(3*dr+2)*PIX_W +: PIX_W];
        end
        cell_data[2*PIX_W +: PIX_W] <= lb0[col];
        cell_data[5*PIX_W +: PIX_W] <= lb1[col];
        cell_data[8*PIX_W +: PIX_W] <= pix_data;

        if (row >= YW'(2) && col >= XW'(2)) begin
          cell_valid <= 1'b1;
          cell_x     <= col - XW'(1);
          cell_y     <= row - YW'(1);
        end

        if (lastCol) begin
          col <= '0;
          row <= lastRow ? '0 : row + YW'(1);
        end else begin
          col <= col + XW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            opcode     <= opcode_in;
            user_input <= user_in;
            col        <= '0;
            row        <= '0;
          end
        end
        LOAD:   if (accept && lastCol && row == YW'(1)) state <= STREAM;
        STREAM: if (accept && lastCol && lastRow) state <= FLUSH;
        FLUSH: begin
          if (handshake) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_window_sequencer.sv
// Directed bench for cell_window_sequencer on a 5x4 frame. Expected cells are
// computed from the pixel formula pix(y,x) = {8'h00, y, x}, queued when the
// pixel is accepted and compared when the cell is handed off.
module tb_cell_window_sequencer;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int P  = 24;
  localparam int OW = 4;
  localparam int CW = 9 * P;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [OW-1:0] opcode_in = '0;
  logic [P-1:0]  user_in = '0;
  logic          pix_valid = 1'b0;
  logic [P-1:0]  pix_data = '0;
  logic          pix_ready;
  logic          cell_valid;
  logic          cell_ready = 1'b1;
  logic [CW-1:0] cell_data;
  logic [XW-1:0] cell_x;
  logic [YW-1:0] cell_y;
  logic [OW-1:0] opcode;
  logic [P-1:0]  user_input;
  logic          busy;
  logic          frame_done;

  cell_window_sequencer #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .OP_W(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode_in(opcode_in), .user_in(user_in),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_data(cell_data),
    .cell_x(cell_x), .cell_y(cell_y), .opcode(opcode), .user_input(user_input),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] data;
  } expT;

  expT           expQ[$];
  expT           popped;
  int            checks = 0;
  int            errors = 0;
  int            cellCount = 0;
  int            doneCount = 0;
  int            cyc = 0;
  logic [CW-1:0] wrapCell = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P-1:0] pixVal(input int y, input int x);
    return {8'h00, 8'(y), 8'(x)};
  endfunction

  function automatic logic [CW-1:0] expCell(input int y, input int x);
    logic [CW-1:0] c;
    c = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        c[(3*dr+dc)*P +: P] = pixVal(y - 2 + dr, x - 2 + dc);
    return c;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) if (frame_done) doneCount++;

  // Output monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && cell_valid && cell_ready) begin
      if (expQ.size() == 0) begin
        chk("cell_unexpected", 1, 0);
      end else begin
        popped = expQ.pop_front();
        chk("cell_x", cell_x, popped.x);
        chk("cell_y", cell_y, popped.y);
        chk("cell_data", cell_data, popped.data);
      end
      cellCount++;
      if (cell_x == XW'(1) && cell_y == YW'(2)) wrapCell = cell_data;
    end
  end

  task automatic sendPixel(input int y, input int x);
    int n;
    pix_valid = 1'b1;
    pix_data  = pixVal(y, x);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ready && n < 50);
    if (!pix_ready) begin
      chk("pix_ready_timeout", 0, 1);
    end else if (y >= 2 && x >= 2) begin
      expQ.push_back('{x: XW'(x - 1), y: YW'(y - 1), data: expCell(y, x)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame(input logic [OW-1:0] op, input logic [P-1:0] usr);
    expQ.delete();
    cellCount = 0;
    opcode_in = op;
    user_in   = usr;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("opcode_latched", opcode, op);
    chk("user_latched", user_input, usr);
    @(posedge clk);
    #1;
  endtask

  // stallIdx: hold cell_ready low 5 cycles after that pixel.
  // busyStartIdx: pulse start (opcode 3) while that pixel is offered.
  // stopIdx: abandon the frame before that pixel.
  task automatic sendFrame(input int stallIdx, input int busyStartIdx, input int stopIdx);
    int firstCyc;
    int n;
    logic [CW-1:0] held;
    firstCyc = 0;
    for (int idx = 0; idx < W * H; idx++) begin
      if (idx == stopIdx) begin
        pix_valid = 1'b0;
        return;
      end
      if (idx == busyStartIdx) begin
        start = 1'b1;
        opcode_in = 4'h3;
      end
      sendPixel(idx / W, idx % W);
      start = 1'b0;
      opcode_in = 4'h1;
      if (idx == 0) firstCyc = cyc - 1;
      if (idx == stallIdx) begin
        cell_ready = 1'b0;
        held = expCell(idx / W, idx % W);
        repeat (5) begin
          @(negedge clk);
          chk("stall_cell_valid", cell_valid, 1);
          chk("stall_pix_ready", pix_ready, 0);
          chk("stall_cell_data", cell_data, held);
        end
        @(posedge clk);
        #1;
        cell_ready = 1'b1;
      end
    end
    pix_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 20);
    chk("done_latency", n, 2);
    if (stallIdx < 0) chk("frame_cycles", cyc - firstCyc + 1, W * H + 2);
    @(negedge clk);
    chk("done_one_cycle", frame_done, 0);
    chk("busy_after_done", busy, 0);
    chk("cell_count", cellCount, (W - 2) * (H - 2));
    chk("queue_empty", expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int doneBefore;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_cell_valid", cell_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cell_data", cell_data, 0);
    chk("rst_cell_xy", {cell_x, cell_y}, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_user", user_input, 0);
    @(posedge clk);
    #1;

    // Small frame, continuous flow
    startFrame(4'h1, 24'h0A0B0C);
    sendFrame(-1, -1, -1);
    chk("opcode_hold", opcode, 4'h1);
    chk("wrap_cell_0", wrapCell[0 +: P], 24'h000100);
    chk("wrap_cell_8", wrapCell[8*P +: P], 24'h000302);
    chk("wrap_cell_2", wrapCell[2*P +: P], 24'h000102);

    // pix_valid while idle is ignored
    pix_valid = 1'b1;
    @(negedge clk);
    chk("idle_pix_ready", pix_ready, 0);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;

    // Backpressure on the first cell
    startFrame(4'h1, 24'h0A0B0C);
    sendFrame(2 * W + 2, -1, -1);

    // Reset mid-frame after 12 pixels
    startFrame(4'h1, 24'h0A0B0C);
    doneBefore = doneCount;
    sendFrame(-1, -1, 12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_cell_valid", cell_valid, 0);
    chk("midrst_opcode", opcode, 0);
    chk("midrst_user", user_input, 0);
    chk("midrst_cell_data", cell_data, 0);
    pix_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_pix_ready", pix_ready, 0);
    chk("midrst_no_done", doneCount, doneBefore);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    startFrame(4'h1, 24'h0A0B0C);
    sendFrame(-1, -1, -1);

    // Start while busy is ignored
    startFrame(4'h1, 24'h0A0B0C);
    sendFrame(-1, 8, -1);
    chk("busy_start_opcode", opcode, 4'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
